dac_wave_gen: RTL and testbench

Parametrised multi-channel waveform generator driving the AN9767 (AD9767) dual 14-bit DAC module. Each channel has its own phase accumulator and runtime-selectable waveform: sawtooth, triangle, square with programmable duty, or DC level. Configuration is written through a simple register bus into shadow registers and applied atomically to all channels on a commit strobe. The block sits between the control logic and the top-level DAC pin mapping; the top level forwards the DAC clocks and write strobes.

---
 rtl/dac_wave_pkg.sv | 22 ++
 rtl/dac_wave_ch.sv | 93 +++++++++
 rtl/dac_wave_gen.sv | 72 +++++++
 tb/tb_dac_wave_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_wave_pkg.sv
// Shared types and constants for the multi-channel DAC waveform generator.
// Mode encoding matches the value written to cfg_wdata[1:0] of the control register.
package dac_wave_pkg;

   typedef enum logic [1:0] {
      MODE_SAW = 2'd0,
      MODE_TRI = 2'd1,
      MODE_SQR = 2'd2,
      MODE_DC  = 2'd3
   } mode_e;

   localparam logic [1:0] SEL_FTW  = 2'd0;
   localparam logic [1:0] SEL_CTRL = 2'd1;
   localparam logic [1:0] SEL_DUTY = 2'd2;
   localparam logic [1:0] SEL_RSVD = 2'd3;

   // Straight-binary code for 0 V on a bipolar DAC output.
   function automatic int unsigned mid_scale(input int unsigned data_w);
      return 32'd1 << (data_w - 1);
   endfunction

endpackage

// File: rtl/dac_wave_ch.sv
// One DAC channel: active config registers, phase accumulator and a two-stage
// shaper (shaped-sample register, then output register).
module dac_wave_ch
   import dac_wave_pkg::*;
#(
   parameter int DATA_W  = 14,
   parameter int PHASE_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_commit,
   input  logic               i_sync,
   input  logic [PHASE_W-1:0] i_sh_ftw,
   input  logic               i_sh_en,
   input  mode_e              i_sh_mode,
   input  logic [DATA_W-1:0]  i_sh_duty,
   output logic [DATA_W-1:0]  o_data,
   output logic               o_valid
);

   localparam logic [DATA_W-1:0] MID = DATA_W'(mid_scale(DATA_W));

   logic [PHASE_W-1:0] r_act_ftw;
   logic               r_act_en;
   mode_e              r_act_mode;
   logic [DATA_W-1:0]  r_act_duty;
   logic [PHASE_W-1:0] r_phase;
   logic [DATA_W-1:0]  r_shape;
   logic               r_en_d1;
   logic [DATA_W-1:0]  r_data;
   logic               r_valid;

   logic [DATA_W:0]    w_p;
   logic [DATA_W-1:0]  w_sq_idx;
   logic [DATA_W-1:0]  w_shape;

   assign w_p      = r_phase[PHASE_W-1 -: DATA_W+1];
   assign w_sq_idx = r_phase[PHASE_W-1 -: DATA_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_act_ftw  <= '0;
         r_act_en   <= 1'b0;
         r_act_mode <= MODE_SAW;
         r_act_duty <= MID;
      end else if (i_commit) begin
         r_act_ftw  <= i_sh_ftw;
         r_act_en   <= i_sh_en;
         r_act_mode <= i_sh_mode;
         r_act_duty <= i_sh_duty;
      end
   end

   // Sync wins over the increment and applies even to disabled channels.
   always_ff @(posedge clk) begin
      if (rst || i_sync) begin
         r_phase <= '0;
      end else if (r_act_en) begin
         r_phase <= r_phase + r_act_ftw;
      end
   end

   always_comb begin
      w_shape = MID;
      if (r_act_en) begin
         case (r_act_mode)
            MODE_SAW: w_shape = w_p[DATA_W:1];
            MODE_TRI: w_shape = w_p[DATA_W] ? ~w_p[DATA_W-1:0] : w_p[DATA_W-1:0];
            MODE_SQR: w_shape = (w_sq_idx < r_act_duty) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            MODE_DC:  w_shape = r_act_duty;
            default:  w_shape = MID;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shape <= MID;
         r_en_d1 <= 1'b0;
         r_data  <= MID;
         r_valid <= 1'b0;
      end else begin
         r_shape <= w_shape;
         r_en_d1 <= r_act_en;
         r_data  <= r_shape;
         r_valid <= r_en_d1;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/dac_wave_gen.sv
// Multi-channel waveform generator for a dual 14-bit DAC: shadow register
// bank with address decode, and a commit that loads every channel at once.
module dac_wave_gen
   import dac_wave_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int DATA_W  = 14,
   parameter int PHASE_W = 32,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_we,
   input  logic [CH_W-1:0]        cfg_ch,
   input  logic [1:0]             cfg_sel,
   input  logic [PHASE_W-1:0]     cfg_wdata,
   input  logic                   cfg_commit,
   input  logic                   sync,
   output logic [N_CH*DATA_W-1:0] da_data,
   output logic [N_CH-1:0]        da_valid
);

   localparam logic [DATA_W-1:0] MID = DATA_W'(mid_scale(DATA_W));

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [PHASE_W-1:0] r_sh_ftw;
      logic               r_sh_en;
      mode_e              r_sh_mode;
      logic [DATA_W-1:0]  r_sh_duty;
      logic               w_hit;

      // Codes at or above N_CH match no channel, so such writes fall away.
      assign w_hit = cfg_we && (cfg_ch == CH_W'(c));

      always_ff @(posedge clk) begin
         if (rst) begin
            r_sh_ftw  <= '0;
            r_sh_en   <= 1'b0;
            r_sh_mode <= MODE_SAW;
            r_sh_duty <= MID;
         end else if (w_hit) begin
            case (cfg_sel)
               SEL_FTW:  r_sh_ftw <= cfg_wdata;
               SEL_CTRL: begin
                  r_sh_en   <= cfg_wdata[2];
                  r_sh_mode <= mode_e'(cfg_wdata[1:0]);
               end
               SEL_DUTY: r_sh_duty <= cfg_wdata[DATA_W-1:0];
               default:  ;
            endcase
         end
      end

      // The channel samples the shadow outputs before this edge's write lands.
      dac_wave_ch #(
         .DATA_W  (DATA_W),
         .PHASE_W (PHASE_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_commit  (cfg_commit),
         .i_sync    (sync),
         .i_sh_ftw  (r_sh_ftw),
         .i_sh_en   (r_sh_en),
         .i_sh_mode (r_sh_mode),
         .i_sh_duty (r_sh_duty),
         .o_data    (da_data[c*DATA_W +: DATA_W]),
         .o_valid   (da_valid[c])
      );
   end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen with two 14-bit channels and 32-bit phase.
// Expected samples come from hand-derived closed forms of each waveform.
module tb_dac_wave_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [0:0]  cfg_ch = 1'b0;
   logic [1:0]  cfg_sel = 2'd0;
   logic [31:0] cfg_wdata = '0;
   logic        cfg_commit = 1'b0;
   logic        sync = 1'b0;
   logic [27:0] da_data;
   logic [1:0]  da_valid;

   int total = 0;
   int bad   = 0;

   always #4 clk = ~clk;

   dac_wave_gen #(.N_CH(2), .DATA_W(14), .PHASE_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_sel    (cfg_sel),
      .cfg_wdata  (cfg_wdata),
      .cfg_commit (cfg_commit),
      .sync       (sync),
      .da_data    (da_data),
      .da_valid   (da_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic ch, input logic [1:0] sel, input logic [31:0] d);
      cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_wdata = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic commit_sync(input logic c, input logic s);
      cfg_commit = c; sync = s;
      tick();
      cfg_commit = 1'b0; sync = 1'b0;
   endtask

   function automatic logic [13:0] tri_exp(input int i);
      int k;
      k = i % 16384;
      return (k < 8192) ? 14'(2 * k) : 14'(16383 - 2 * (k - 8192));
   endfunction

   task automatic test_reset();
      logic [29:0] exp_v;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      exp_v = {2'b00, 14'h2000, 14'h2000};
      total++;
      if ({da_valid, da_data} !== exp_v) begin
         bad++;
         $display("FAIL reset got=%h exp=%h", {da_valid, da_data}, exp_v);
      end
   endtask

   task automatic test_saw();
      logic [29:0] exp_v;
      wr(1'b0, 2'd0, 32'h0004_0000);
      wr(1'b0, 2'd1, 32'h4);
      commit_sync(1'b1, 1'b0);
      tick();
      exp_v = {2'b00, 14'h2000, 14'h2000};
      total++;
      if ({da_valid, da_data} !== exp_v) begin
         bad++;
         $display("FAIL saw_latency got=%h exp=%h", {da_valid, da_data}, exp_v);
      end
      for (int i = 0; i <= 16384; i++) begin
         tick();
         exp_v = {2'b01, 14'h2000, 14'(i)};
         total++;
         if ({da_valid, da_data} !== exp_v) begin
            bad++;
            $display("FAIL saw i=%0d got=%h exp=%h", i, {da_valid, da_data}, exp_v);
         end
      end
   endtask

   task automatic test_triangle();
      logic [15:0] exp_v;
      wr(1'b1, 2'd0, 32'h0004_0000);
      wr(1'b1, 2'd1, 32'h5);
      commit_sync(1'b1, 1'b0);
      tick();
      total++;
      if ({da_valid[1], da_data[27:14]} !== {1'b0, 14'h2000}) begin
         bad++;
         $display("FAIL tri_latency got=%h exp=%h", {da_valid[1], da_data[27:14]}, {1'b0, 14'h2000});
      end
      for (int i = 0; i <= 16384; i++) begin
         tick();
         exp_v = {2'b11, tri_exp(i)};
         total++;
         if ({da_valid, da_data[27:14]} !== exp_v) begin
            bad++;
            $display("FAIL tri i=%0d got=%h exp=%h", i, {da_valid, da_data[27:14]}, exp_v);
         end
      end
   endtask

   task automatic test_square();
      logic [29:0] exp_v;
      logic [13:0] sq;
      wr(1'b0, 2'd2, 32'h1000);
      wr(1'b0, 2'd1, 32'h6);
      commit_sync(1'b1, 1'b1);
      tick();
      for (int i = 0; i < 16384 + 8; i++) begin
         tick();
         sq = ((i % 16384) < 4096) ? 14'h3FFF : 14'h0000;
         exp_v = {2'b11, tri_exp(i), sq};
         total++;
         if ({da_valid, da_data} !== exp_v) begin
            bad++;
            $display("FAIL square i=%0d got=%h exp=%h", i, {da_valid, da_data}, exp_v);
         end
      end
   endtask

   task automatic check_rates(input string name, input int s0, input int s1, input int n);
      logic [29:0] exp_v;
      tick();
      for (int i = 0; i < n; i++) begin
         tick();
         exp_v = {2'b11, 14'(s1 * i), 14'(s0 * i)};
         total++;
         if ({da_valid, da_data} !== exp_v) begin
            bad++;
            $display("FAIL %s i=%0d got=%h exp=%h", name, i, {da_valid, da_data}, exp_v);
         end
      end
   endtask

   task automatic test_coherent_commit();
      logic [29:0] exp_v;
      wr(1'b0, 2'd0, 32'h0008_0000);
      wr(1'b0, 2'd1, 32'h4);
      wr(1'b1, 2'd0, 32'h000C_0000);
      wr(1'b1, 2'd1, 32'h4);
      // Sync alone: the old square/triangle config must still be active.
      commit_sync(1'b0, 1'b1);
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_v = {2'b11, tri_exp(i), 14'h3FFF};
         total++;
         if ({da_valid, da_data} !== exp_v) begin
            bad++;
            $display("FAIL no_commit i=%0d got=%h exp=%h", i, {da_valid, da_data}, exp_v);
         end
      end
      commit_sync(1'b1, 1'b1);
      check_rates("commit_both", 2, 3, 8);
      wr(1'b0, 2'd0, 32'h0004_0000);
      cfg_we = 1'b1; cfg_ch = 1'b0; cfg_sel = 2'd0; cfg_wdata = 32'h0010_0000;
      commit_sync(1'b1, 1'b1);
      cfg_we = 1'b0;
      check_rates("we_with_commit", 1, 3, 8);
      commit_sync(1'b1, 1'b1);
      check_rates("later_commit", 4, 3, 8);
   endtask

   task automatic test_sync();
      repeat (37) tick();
      commit_sync(1'b0, 1'b1);
      check_rates("sync", 4, 3, 10);
   endtask

   task automatic test_reset_mid();
      logic [29:0] exp_v;
      wr(1'b0, 2'd1, 32'h5);
      wr(1'b1, 2'd1, 32'h5);
      commit_sync(1'b1, 1'b0);
      repeat (50) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_v = {2'b00, 14'h2000, 14'h2000};
      total++;
      if ({da_valid, da_data} !== exp_v) begin
         bad++;
         $display("FAIL reset_mid got=%h exp=%h", {da_valid, da_data}, exp_v);
      end
      commit_sync(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if ({da_valid, da_data} !== exp_v) begin
            bad++;
            $display("FAIL reset_commit i=%0d got=%h exp=%h", i, {da_valid, da_data}, exp_v);
         end
      end
   endtask

   task automatic test_dc_and_disable();
      logic [29:0] exp_v;
      wr(1'b0, 2'd1, 32'h7);
      wr(1'b1, 2'd2, 32'h1234);
      wr(1'b1, 2'd1, 32'h7);
      wr(1'b1, 2'd3, 32'h0);
      commit_sync(1'b1, 1'b0);
      tick();
      exp_v = {2'b00, 14'h2000, 14'h2000};
      total++;
      if ({da_valid, da_data} !== exp_v) begin
         bad++;
         $display("FAIL dc_latency got=%h exp=%h", {da_valid, da_data}, exp_v);
      end
      tick();
      exp_v = {2'b11, 14'h1234, 14'h2000};
      total++;
      if ({da_valid, da_data} !== exp_v) begin
         bad++;
         $display("FAIL dc got=%h exp=%h", {da_valid, da_data}, exp_v);
      end
      wr(1'b0, 2'd1, 32'h2);
      commit_sync(1'b1, 1'b0);
      tick(); tick();
      exp_v = {2'b10, 14'h1234, 14'h2000};
      total++;
      if ({da_valid, da_data} !== exp_v) begin
         bad++;
         $display("FAIL disabled got=%h exp=%h", {da_valid, da_data}, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_saw();
      test_triangle();
      test_square();
      test_coherent_commit();
      test_sync();
      test_reset_mid();
      test_dc_and_disable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
